// File: rtl/memory_pkg.sv
// memory_pkg: shared types for the burst memory block.
// Burst-size enum, FSM state enum and burst_len() helper.
package memory_pkg;

  typedef enum logic [1:0] {
    SZ_1  = 2'b00,
    SZ_4  = 2'b01,
    SZ_8  = 2'b10,
    SZ_16 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    XFER = 2'b10
  } state_e;

  function automatic logic [4:0] burst_len(size_e s);
    logic [4:0] n;
    n = 5'd1;
    case (s)
      SZ_1:    n = 5'd1;
      SZ_4:    n = 5'd4;
      SZ_8:    n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/memory_array.sv
// memory_array: single-port synchronous RAM, 1-cycle read.
// Ports: clk_i, we_i, re_i, addr_i, wdata_i -> rdata_o.
module memory_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_burst.sv
// memory_burst: burst read/write front end over memory_array.
// Ports: clk, reset_n, enable, read_write, access_size, address,
// data_in -> data_out, data_valid, busy, error.
module memory_burst
  import memory_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8002_0000,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              read_write,
  input  logic [1:0]        access_size,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic        rw_q, rw_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  iss_q, iss_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] off;
  logic          addr_ok;
  logic [AW-1:0] w_idx;
  logic [4:0]    n;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata, pipe_out;

  assign off   = address - BASE_ADDR;
  assign w_idx = off[AW+1:2];
  assign n     = burst_len(size_e'(access_size));
  assign addr_ok = (address[1:0] == 2'b00)
                && (address >= BASE_ADDR)
                && (off < ADDR_W'(4 * DEPTH_WORDS));

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    iss_d    = iss_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = idx_q;

    // Read addresses are issued back to back from accept,
    // independent of WAIT; the output pipe absorbs latency.
    if (iss_q != 5'd0) begin
      ram_re = 1'b1;
      idx_d  = idx_q + 1'b1;
      iss_d  = iss_q - 5'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (enable && !addr_ok) begin
          err_d = 1'b1;
        end else if (enable) begin
          rw_d     = read_write;
          len_d    = n;
          ram_addr = w_idx;
          idx_d    = w_idx + 1'b1;
          if (read_write) begin
            ram_re = 1'b1;
            iss_d  = n - 5'd1;
            if (RD_LATENCY > 1) begin
              state_d = WAIT;
              cnt_d   = 5'(RD_LATENCY - 2);
            end else begin
              state_d = XFER;
              cnt_d   = n - 5'd1;
            end
          end else begin
            ram_we = 1'b1;
            if (n > 5'd1) begin
              state_d = XFER;
              cnt_d   = n - 5'd2;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == 5'd0) begin
          state_d = XFER;
          cnt_d   = len_q - 5'd1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      XFER: begin
        if (!rw_q) begin
          ram_we = 1'b1;
          idx_d  = idx_q + 1'b1;
        end
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      len_q   <= 5'd0;
      cnt_q   <= 5'd0;
      iss_q   <= 5'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Write strobe is gated so a reset edge never stores a beat.
  memory_array #(
    .DATA_W     (DATA_W),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ram_we & reset_n),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(data_in),
    .rdata_o(ram_rdata)
  );

  if (RD_LATENCY > 1) begin : g_pipe
    logic [DATA_W-1:0] pipe_q [RD_LATENCY-1];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < RD_LATENCY-1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= ram_rdata;
        for (int i = 1; i < RD_LATENCY-1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end
    assign pipe_out = pipe_q[RD_LATENCY-2];
  end else begin : g_nopipe
    assign pipe_out = ram_rdata;
  end

  assign busy       = (state_q != IDLE);
  assign data_valid = (state_q == XFER) && rw_q;
  assign data_out   = data_valid ? pipe_out : '0;
  assign error      = err_q;

endmodule

// File: tb/tb_memory_burst.sv
// tb_memory_burst: scoreboard bench for memory_burst.
// Two instances: RD_LATENCY=1 (dut) and RD_LATENCY=3 (dut3).
module tb_memory_burst;
  import memory_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic enable3 = 1'b0;
  logic read_write = 1'b0;
  logic [1:0] access_size = 2'b00;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;

  logic [31:0] data_out, data_out3;
  logic data_valid, busy, error;
  logic dv3, busy3, err3;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int beats3 = 0;
  logic [31:0] mdl  [DEPTH];
  logic [31:0] mdl3 [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] exp3_q[$];
  logic [31:0] exp_v, exp3_v;

  always #5 clk = ~clk;

  memory_burst #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .read_write(read_write), .access_size(access_size),
    .address(address), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .error(error)
  );

  memory_burst #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE), .RD_LATENCY(3)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable3),
    .read_write(read_write), .access_size(access_size),
    .address(address), .data_in(data_in),
    .data_out(data_out3), .data_valid(dv3),
    .busy(busy3), .error(err3)
  );

  function automatic int blen(logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int widx(logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o % DEPTH);
  endfunction

  always @(negedge clk) begin : mon
    if (data_valid) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_beat unexpected got=%h", data_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (data_out !== exp_v) begin
          failures++;
          $display("FAIL rd_beat got=%h exp=%h", data_out, exp_v);
        end
      end
    end else begin
      checks++;
      if (data_out !== 32'h0) begin
        failures++;
        $display("FAIL idle_dout got=%h exp=0", data_out);
      end
    end
  end

  always @(negedge clk) begin : mon3
    if (dv3) begin
      beats3++;
      checks++;
      if (exp3_q.size() == 0) begin
        failures++;
        $display("FAIL rd3_beat unexpected got=%h", data_out3);
      end else begin
        exp3_v = exp3_q.pop_front();
        if (data_out3 !== exp3_v) begin
          failures++;
          $display("FAIL rd3_beat got=%h exp=%h", data_out3, exp3_v);
        end
      end
    end
  end

  task automatic set_en(input bit which, input logic v);
    if (which) enable3 = v;
    else enable = v;
  endtask

  task automatic do_write(input bit which, input logic [31:0] a,
                          input logic [1:0] sz,
                          input logic [31:0] d [16]);
    int n, nb, w;
    n = blen(sz);
    nb = 0;
    w = widx(a);
    @(negedge clk);
    set_en(which, 1'b1);
    read_write = 1'b0;
    address = a;
    access_size = sz;
    data_in = d[0];
    for (int i = 0; i < n; i++) begin
      if (which) mdl3[(w + i) % DEPTH] = d[i];
      else mdl[(w + i) % DEPTH] = d[i];
    end
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      set_en(which, 1'b0);
      if (which ? busy3 : busy) nb++;
      data_in = d[i];
    end
    @(negedge clk);
    set_en(which, 1'b0);
    if (which ? busy3 : busy) nb++;
    checks++;
    if (nb !== n - 1) begin
      failures++;
      $display("FAIL wr_busy_cycles got=%0d exp=%0d", nb, n - 1);
    end
  endtask

  task automatic do_read(input bit which, input logic [31:0] a,
                         input logic [1:0] sz, input bit pulse);
    int n, nb, lat, b0, w, lexp;
    bit done;
    n = blen(sz);
    w = widx(a);
    lexp = which ? 3 : 1;
    nb = 0;
    lat = -1;
    done = 1'b0;
    b0 = which ? beats3 : beats;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (which) exp3_q.push_back(mdl3[(w + i) % DEPTH]);
      else exp_q.push_back(mdl[(w + i) % DEPTH]);
    end
    set_en(which, 1'b1);
    read_write = 1'b1;
    address = a;
    access_size = sz;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      set_en(which, 1'b0);
      read_write = 1'b1;
      if (pulse && (c == 2 || c == 5)) begin
        set_en(which, 1'b1);
        read_write = 1'b0;
        address = a;
        access_size = 2'b00;
        data_in = 32'h0000_0BAD;
      end
      if ((which ? dv3 : data_valid) && lat < 0) lat = c;
      if (which ? busy3 : busy) nb++;
      else done = 1'b1;
    end
    set_en(which, 1'b0);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rd_timeout busy never fell");
    end
    checks++;
    if (lat !== lexp) begin
      failures++;
      $display("FAIL rd_latency got=%0d exp=%0d", lat, lexp);
    end
    checks++;
    if (nb !== n + lexp - 1) begin
      failures++;
      $display("FAIL rd_busy_cycles got=%0d exp=%0d", nb, n + lexp - 1);
    end
    checks++;
    if ((which ? beats3 : beats) - b0 !== n) begin
      failures++;
      $display("FAIL rd_beat_count got=%0d exp=%0d",
               (which ? beats3 : beats) - b0, n);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    read_write = 1'b1;
    address = BASE;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, data_valid, error, data_out} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outs got=%b%b%b %h exp=0",
               busy, data_valid, error, data_out);
    end
    enable = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept busy=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    logic [31:0] d [16];
    foreach (d[i]) d[i] = 32'h0;
    d[0] = 32'd234;
    do_write(1'b0, BASE, 2'b00, d);
    do_read(1'b0, BASE, 2'b00, 1'b0);
  endtask

  task automatic test_burst4();
    logic [31:0] d [16];
    foreach (d[i]) d[i] = 32'(i + 1);
    do_write(1'b0, BASE + 32'h10, 2'b01, d);
    do_read(1'b0, BASE + 32'h10, 2'b01, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] d [16];
    logic [31:0] top;
    top = BASE + 32'(4 * (DEPTH - 1));
    foreach (d[i]) d[i] = 32'(100 + i);
    do_write(1'b0, top, 2'b11, d);
    do_read(1'b0, top, 2'b11, 1'b0);
    do_read(1'b0, BASE, 2'b00, 1'b0);
  endtask

  task automatic test_reject();
    logic [31:0] bad [3];
    bad[0] = BASE + 32'h2;
    bad[1] = BASE - 32'h4;
    bad[2] = BASE + 32'(4 * DEPTH);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      enable = 1'b1;
      read_write = 1'b0;
      access_size = 2'b01;
      address = bad[k];
      data_in = 32'hDEAD_0000;
      @(negedge clk);
      enable = 1'b0;
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reject_pulse err=%b busy=%b exp=1,0", error, busy);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reject_clear err=%b busy=%b exp=0,0", error, busy);
      end
    end
    do_read(1'b0, BASE, 2'b01, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d [16];
    foreach (d[i]) d[i] = 32'(32'h40 + i);
    do_write(1'b0, BASE + 32'h40, 2'b10, d);
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back(mdl[16 + i]);
    enable = 1'b1;
    read_write = 1'b1;
    address = BASE + 32'h40;
    access_size = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      enable = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({busy, data_valid, data_out} !== 34'h0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b %h exp=0",
               busy, data_valid, data_out);
    end
    checks++;
    if (exp_q.size() !== 4) begin
      failures++;
      $display("FAIL mid_reset_left got=%0d exp=4", exp_q.size());
    end
    exp_q.delete();
    do_read(1'b0, BASE + 32'h44, 2'b00, 1'b0);
  endtask

  task automatic test_latency();
    logic [31:0] d [16];
    foreach (d[i]) d[i] = 32'(32'h300 + i);
    do_write(1'b1, BASE + 32'h80, 2'b10, d);
    do_read(1'b1, BASE + 32'h80, 2'b10, 1'b1);
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b0) begin
      failures++;
      $display("FAIL lat_extra_xfer busy3=%b exp=0", busy3);
    end
    do_read(1'b1, BASE + 32'h80, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_wrap();
    test_reject();
    test_reset_mid();
    test_latency();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
